// File: rtl/core_rf_wr_arbiter.sv
// Register-file write-port arbiter: two requesters, each with its own small FIFO.
// Round-robin between the FIFO heads on contention, with a registered write port and a pending-register mask.
module core_rf_wr_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] pending_mask
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    logic [1:0]    in_valid;
    logic [4:0]    in_addr [2];
    logic [31:0]   in_data [2];
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    head_v;
    logic [1:0]    grant;

    logic [4:0]    addr_q [2][DEPTH];
    logic [31:0]   data_q [2][DEPTH];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [CW-1:0] count_q [2];
    logic [CW-1:0] count_d [2];
    logic          rr_q, rr_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    // Ready depends only on occupancy, so a write is never accepted on the strength of a same-cycle pop.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            ready[n]  = !rst && (count_q[n] < CW'(DEPTH));
            push[n]   = in_valid[n] && ready[n] && (in_addr[n] != 5'd0);
            head_v[n] = (count_q[n] != '0);
        end
        grant[0] = head_v[0] && (!head_v[1] || !rr_q);
        grant[1] = head_v[1] && (!head_v[0] || rr_q);
    end

    always_comb begin
        rr_d      = rr_q;
        wr_en_d   = |grant;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        for (int n = 0; n < 2; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n] + PW'(push[n]);
            rd_ptr_d[n] = rd_ptr_q[n] + PW'(grant[n]);
            count_d[n]  = count_q[n] + CW'(push[n]) - CW'(grant[n]);
        end
        if (grant[0]) begin
            wr_addr_d = addr_q[0][rd_ptr_q[0]];
            wr_data_d = data_q[0][rd_ptr_q[0]];
        end else if (grant[1]) begin
            wr_addr_d = addr_q[1][rd_ptr_q[1]];
            wr_data_d = data_q[1][rd_ptr_q[1]];
        end
        if (&head_v) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                rd_ptr_q[n] <= '0;
                wr_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
            rr_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                rd_ptr_q[n] <= rd_ptr_d[n];
                wr_ptr_q[n] <= wr_ptr_d[n];
                count_q[n]  <= count_d[n];
            end
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                addr_q[n][wr_ptr_q[n]] <= in_addr[n];
                data_q[n][wr_ptr_q[n]] <= in_data[n];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy count.
    always_comb begin
        logic [PW-1:0] off;
        off          = '0;
        pending_mask = '0;
        for (int n = 0; n < 2; n++) begin
            for (int s = 0; s < DEPTH; s++) begin
                off = PW'(s) - rd_ptr_q[n];
                if ({1'b0, off} < count_q[n]) begin
                    pending_mask[addr_q[n][s]] = 1'b1;
                end
            end
        end
        pending_mask[0] = 1'b0;
        if (rst) begin
            pending_mask = '0;
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
endmodule

// File: doc/core_rf_wr_arbiter.md
CORE_RF_WR_ARBITER -- requirements
Module: core_rf_wr_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, per-requester write-buffer depth in entries; legal values 2 and 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write.
REQ-005 req0_ready  output  1  requester 0 buffer can accept a write.
REQ-006 req0_addr  input  5  requester 0 destination register.
REQ-007 req0_data  input  32  requester 0 write data.
REQ-008 req1_valid / req1_ready / req1_addr / req1_data  in/out/in/in  1/1/5/32  requester 1 (load unit), same meaning.
REQ-009 wr_en  output  1  register-file write enable.
REQ-010 wr_addr  output  5  register-file write address.
REQ-011 wr_data  output  32  register-file write data.
REQ-012 pending_mask  output  32  bit r set = write to register r accepted but not yet presented on wr_*.

Function
REQ-013 The block SHALL share the register file's single write port between two requesters through one FIFO of DEPTH entries per requester.
REQ-014 A write is accepted on a rising edge where reqN_valid and reqN_ready are both 1.
REQ-015 reqN_ready SHALL be 1 iff rst is 0 and FIFO N holds fewer than DEPTH entries; it SHALL NOT depend on reqN_valid or on a same-cycle pop.
REQ-016 An accepted write with addr 0 SHALL be discarded: no FIFO entry, no wr_en, no pending_mask bit.
REQ-017 Each cycle the arbiter SHALL grant at most one non-empty FIFO head; the granted entry is popped and loaded into the wr_* output register at that edge.
REQ-018 Only one head valid: that FIFO is granted.
REQ-019 Both heads valid: the FIFO selected by 1-bit rr_ptr is granted; rr_ptr then points to the other FIFO.
REQ-020 rr_ptr SHALL change only on a both-valid grant.
REQ-021 wr_en/wr_addr/wr_data are registered; wr_en is 1 for exactly one cycle per granted entry; when no grant, wr_en is 0 and wr_addr/wr_data hold their last values.
REQ-022 Latency: write accepted at edge E into an empty FIFO with no contention SHALL appear on wr_* in the cycle after edge E+1 (2 cycles).
REQ-023 Throughput: one register-file write per cycle while any FIFO is non-empty.
REQ-024 Order within a requester SHALL be preserved; no ordering is guaranteed between requesters.
REQ-025 pending_mask SHALL be combinational OR of one-hot decodes of all valid FIFO entries; bit 0 is always 0; an entry's bit clears in the cycle wr_en presents it.
REQ-026 Push and pop on the same FIFO in the same edge SHALL leave its count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-027 Two writes to the same register from both requesters SHALL both be performed, in grant order.

Reset
REQ-028 While rst is 1 at an edge: both FIFOs emptied, rr_ptr = 0 (requester 0 preferred), wr_en = 0, wr_addr = 0, wr_data = 0.
REQ-029 During and after reset: reqN_ready = 0 while rst = 1, then 1; pending_mask = 0.
REQ-030 Reset mid-operation SHALL discard all buffered writes; no wr_en in the cycle after the reset edge.

Verification
REQ-031 Single write: req0 addr 5 data 0x1234 for one cycle -> wr_en=1, wr_addr=5, wr_data=0x1234 two cycles later; pending_mask bit5 high one cycle in between.
REQ-032 Contention: both valid each cycle, req0 addrs 1,2 and req1 addrs 3,4 -> wr_addr sequence 1,3,2,4 (after reset), one per cycle, no gaps.
REQ-033 Backpressure: req1 writes 3 times back to back, DEPTH=2, with req0 flooding -> req1_ready drops to 0 when its FIFO is full; no write is lost or duplicated.
REQ-034 x0: req0 addr 0 data 0xFFFFFFFF -> accepted, wr_en never asserted, pending_mask stays 0.
REQ-035 Reset mid-stream: both FIFOs full, assert rst one cycle -> wr_en 0 thereafter, pending_mask 0, readies 1 after rst falls, and the next write is granted to requester 0 first on contention.
